seq_detect_param: RTL and testbench

- Parametrised serial bit-pattern detector, successor to the fixed 4-bit "1101" detector FSMs in the FSM sequence-detector family.
- Pattern width, reset pattern, overlap mode and match-counter width are parameters. The pattern is reloadable at runtime.
- Adds input qualification (in_valid), a saturating match counter and counter clear.
- Sits between a serial bit source and status/interrupt logic.

---
 rtl/seq_detect_param.sv | 82 ++++++++
 tb/tb_seq_detect_param.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/seq_detect_param.sv
// seq_detect_param: parametrised serial bit-pattern detector with runtime
// pattern reload, input qualification, optional overlap and a saturating
// match counter.
module seq_detect_param #(
    parameter int unsigned      PAT_W       = 4,
    parameter logic [PAT_W-1:0] DEFAULT_PAT = 4'b1101,
    parameter bit               OVERLAP     = 1'b1,
    parameter int unsigned      CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             pat_load,
    input  logic [PAT_W-1:0] pat_in,
    input  logic             cnt_clr,
    output logic             match,
    output logic [CNT_W-1:0] match_count,
    output logic [PAT_W-1:0] pattern
);

    localparam int unsigned FILL_W = $clog2(PAT_W + 1);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);

    // hist holds the last accepted bits, oldest in the MSB; fill counts how
    // many of them are valid since reset, reload or a non-overlapping hit.
    logic [PAT_W-1:0]  hist;
    logic [PAT_W-1:0]  hist_nx;
    logic [PAT_W-1:0]  shifted;
    logic [FILL_W-1:0] fill;
    logic [FILL_W-1:0] fill_nx;
    logic [FILL_W-1:0] fill_inc;
    logic [CNT_W-1:0]  count_nx;
    logic              accept;
    logic              hit;

    // Next-state: shift history, detect a hit, update the saturating counter.
    always_comb begin
        accept   = in_valid && !pat_load;
        shifted  = {hist[PAT_W-2:0], in_bit};
        fill_inc = (fill == FILL_FULL) ? FILL_FULL : fill + 1'b1;
        hit      = accept && (fill_inc == FILL_FULL) && (shifted == pattern);

        hist_nx  = hist;
        fill_nx  = fill;
        if (pat_load) begin
            hist_nx = '0;
            fill_nx = '0;
        end else if (accept) begin
            hist_nx = shifted;
            fill_nx = (hit && !OVERLAP) ? '0 : fill_inc;
        end

        count_nx = match_count;
        if (cnt_clr) begin
            // Clear then count: a hit on the clearing edge leaves a count of one.
            count_nx = hit ? CNT_W'(1) : '0;
        end else if (hit && (match_count != '1)) begin
            count_nx = match_count + 1'b1;
        end
    end

    // State register; reset overrides load, clear and data.
    always_ff @(posedge clk) begin
        if (rst) begin
            hist        <= '0;
            fill        <= '0;
            pattern     <= DEFAULT_PAT;
            match       <= 1'b0;
            match_count <= '0;
        end else begin
            hist        <= hist_nx;
            fill        <= fill_nx;
            match       <= hit;
            match_count <= count_nx;
            if (pat_load) begin
                pattern <= pat_in;
            end
        end
    end

endmodule

// File: tb/tb_seq_detect_param.sv
// Testbench for seq_detect_param: three builds (default, non-overlapping,
// 2-bit counter) share one stimulus bus; each scenario checks its own build.
module tb_seq_detect_param;

    logic       clk = 1'b0;
    logic       rst, in_valid, in_bit, pat_load, cnt_clr;
    logic [3:0] pat_in;

    logic       m_ov, m_no, m_sat;
    logic [7:0] c_ov, c_no;
    logic [1:0] c_sat;
    logic [3:0] p_ov, p_no, p_sat;

    typedef struct {
        logic       v, b, ld;
        logic [3:0] pin;
        logic       clr, r, em;
        logic [7:0] ec;
    } step_t;

    typedef struct {
        logic       m;
        logic [7:0] c;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk = ~clk;

    seq_detect_param dut_ov (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .match(m_ov), .match_count(c_ov), .pattern(p_ov)
    );

    seq_detect_param #(.OVERLAP(1'b0)) dut_no (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .match(m_no), .match_count(c_no), .pattern(p_no)
    );

    seq_detect_param #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_bit(in_bit),
        .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
        .match(m_sat), .match_count(c_sat), .pattern(p_sat)
    );

    function automatic step_t bitstep(input logic b, input logic em, input logic [7:0] ec);
        step_t s = '{v: 1'b1, b: b, ld: 1'b0, pin: 4'b0, clr: 1'b0, r: 1'b0, em: em, ec: ec};
        return s;
    endfunction

    function automatic step_t idlestep(input logic [7:0] ec);
        step_t s = '{v: 1'b0, b: 1'b0, ld: 1'b0, pin: 4'b0, clr: 1'b0, r: 1'b0, em: 1'b0, ec: ec};
        return s;
    endfunction

    function automatic step_t rststep();
        step_t s = '{v: 1'b0, b: 1'b0, ld: 1'b0, pin: 4'b0, clr: 1'b0, r: 1'b1, em: 1'b0, ec: 8'd0};
        return s;
    endfunction

    function automatic step_t loadstep(input logic [3:0] pin, input logic v, input logic b,
                                       input logic [7:0] ec);
        step_t s = '{v: v, b: b, ld: 1'b1, pin: pin, clr: 1'b0, r: 1'b0, em: 1'b0, ec: ec};
        return s;
    endfunction

    // Apply one step for one clock edge, queueing its expected result.
    task automatic drive(input step_t s);
        in_valid = s.v;
        in_bit   = s.b;
        pat_load = s.ld;
        pat_in   = s.pin;
        cnt_clr  = s.clr;
        rst      = s.r;
        sb.push_back('{m: s.em, c: s.ec});
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        step_t s;
        exp_t  e;
        // Reset asserted together with every other control: reset must win.
        s = '{v: 1'b1, b: 1'b1, ld: 1'b1, pin: 4'b0000, clr: 1'b1, r: 1'b1, em: 1'b0, ec: 8'd0};
        drive(s);
        drive(s);
        for (int i = 0; i < 2; i++) begin
            e = sb.pop_front();
            n_cmp++;
            if (m_ov !== e.m || c_ov !== e.c || m_no !== e.m || c_no !== e.c ||
                m_sat !== e.m || {6'b0, c_sat} !== e.c) begin
                n_bad++;
                $display("FAIL reset_outputs: match=%b/%b/%b count=%0d/%0d/%0d, required match=%b count=%0d",
                         m_ov, m_no, m_sat, c_ov, c_no, c_sat, e.m, e.c);
            end
        end
        n_cmp++;
        if (p_ov !== 4'b1101 || p_no !== 4'b1101 || p_sat !== 4'b1101) begin
            n_bad++;
            $display("FAIL reset_pattern: got %b/%b/%b, required 1101", p_ov, p_no, p_sat);
        end
    endtask

    task automatic test_overlap();
        logic [9:0] bits = 10'b1101101101;
        logic [9:0] em   = 10'b0001001001;
        logic [7:0] ec[10] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3};
        step_t st[$];
        exp_t  e;
        st.push_back(rststep());
        for (int i = 0; i < 10; i++) st.push_back(bitstep(bits[9-i], em[9-i], ec[i]));
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            n_cmp++;
            if (m_ov !== e.m || c_ov !== e.c) begin
                n_bad++;
                $display("FAIL overlap step %0d: match=%b count=%0d, required match=%b count=%0d",
                         i, m_ov, c_ov, e.m, e.c);
            end
        end
    endtask

    task automatic test_nonoverlap();
        logic [9:0] bits = 10'b1101101101;
        logic [9:0] em   = 10'b0001000001;
        logic [7:0] ec[10] = '{0, 0, 0, 1, 1, 1, 1, 1, 1, 2};
        step_t st[$];
        exp_t  e;
        st.push_back(rststep());
        for (int i = 0; i < 10; i++) st.push_back(bitstep(bits[9-i], em[9-i], ec[i]));
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            n_cmp++;
            if (m_no !== e.m || c_no !== e.c) begin
                n_bad++;
                $display("FAIL nonoverlap step %0d: match=%b count=%0d, required match=%b count=%0d",
                         i, m_no, c_no, e.m, e.c);
            end
        end
    endtask

    task automatic test_gaps_reset();
        logic [3:0] bits = 4'b1101;
        step_t st[$];
        exp_t  e;
        st.push_back(rststep());
        for (int i = 0; i < 4; i++) begin
            st.push_back(bitstep(bits[3-i], (i == 3), (i == 3) ? 8'd1 : 8'd0));
            if (i < 3) for (int k = 0; k < 3; k++) st.push_back(idlestep(8'd0));
        end
        st.push_back(bitstep(1'b1, 1'b0, 8'd1));
        st.push_back(bitstep(1'b1, 1'b0, 8'd1));
        st.push_back(bitstep(1'b0, 1'b0, 8'd1));
        st.push_back(rststep());
        st.push_back(bitstep(1'b1, 1'b0, 8'd0));
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            n_cmp++;
            if (m_ov !== e.m || c_ov !== e.c) begin
                n_bad++;
                $display("FAIL gaps step %0d: match=%b count=%0d, required match=%b count=%0d",
                         i, m_ov, c_ov, e.m, e.c);
            end
        end
        n_cmp++;
        if (p_ov !== 4'b1101) begin
            n_bad++;
            $display("FAIL gaps_pattern: got %b, required 1101", p_ov);
        end
    endtask

    task automatic test_reload();
        logic [6:0] bits = 7'b0110110;
        logic [6:0] em   = 7'b0001001;
        logic [7:0] ec[7] = '{0, 0, 0, 1, 1, 1, 2};
        step_t st[$];
        exp_t  e;
        st.push_back(rststep());
        st.push_back(loadstep(4'b0110, 1'b1, 1'b0, 8'd0));
        for (int i = 0; i < 7; i++) st.push_back(bitstep(bits[6-i], em[6-i], ec[i]));
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            n_cmp++;
            if (m_ov !== e.m || c_ov !== e.c) begin
                n_bad++;
                $display("FAIL reload step %0d: match=%b count=%0d, required match=%b count=%0d",
                         i, m_ov, c_ov, e.m, e.c);
            end
        end
        n_cmp++;
        if (p_ov !== 4'b0110) begin
            n_bad++;
            $display("FAIL reload_pattern: got %b, required 0110", p_ov);
        end
    endtask

    task automatic test_saturate_clear();
        logic [18:0] bits = 19'b1101101101101101101;
        logic [18:0] em   = 19'b0001001001001001001;
        logic [7:0]  ec[19] = '{0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 3, 3, 3, 3, 3, 3, 1};
        step_t st[$];
        step_t s;
        exp_t  e;
        st.push_back(rststep());
        for (int i = 0; i < 19; i++) begin
            s = bitstep(bits[18-i], em[18-i], ec[i]);
            if (i == 18) s.clr = 1'b1;
            st.push_back(s);
        end
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            n_cmp++;
            if (m_sat !== e.m || {6'b0, c_sat} !== e.c) begin
                n_bad++;
                $display("FAIL saturate step %0d: match=%b count=%0d, required match=%b count=%0d",
                         i, m_sat, c_sat, e.m, e.c);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [5:0] em = 6'b000111;
        logic [7:0] ec[6] = '{0, 0, 0, 1, 2, 3};
        step_t st[$];
        exp_t  e;
        st.push_back(rststep());
        st.push_back(loadstep(4'b1111, 1'b0, 1'b0, 8'd0));
        for (int i = 0; i < 6; i++) st.push_back(bitstep(1'b1, em[5-i], ec[i]));
        foreach (st[i]) begin
            drive(st[i]);
            e = sb.pop_front();
            n_cmp++;
            if (m_ov !== e.m || c_ov !== e.c) begin
                n_bad++;
                $display("FAIL back_to_back step %0d: match=%b count=%0d, required match=%b count=%0d",
                         i, m_ov, c_ov, e.m, e.c);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_bit = 1'b0;
        pat_load = 1'b0; pat_in = 4'b0; cnt_clr = 1'b0;
        #2;
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_gaps_reset();
        test_reload();
        test_saturate_clear();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
